// File: rtl/alu_exc_unit.sv
// alu_exc_unit: captures committing ALU results, accumulates sticky status
// flags and raises a precise exception (with cause and pc) for masked flags.
// FSM: IDLE accepts results; TRAP holds the pipeline until the handler acks;
// DRAIN adds one extra stall cycle before returning to IDLE.
// Optional feature: define ALU_EXC_COUNT_EN to add the saturating exc_count
// output that counts IDLE->TRAP transitions.
module alu_exc_unit #(
  parameter logic [7:0] EXC_MASK = 8'b0100_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [31:0] ALU_result,
  input  logic [7:0]  ALU_status,
  input  logic [31:0] pc,
  input  logic        exc_ack,
  input  logic        flag_clr,
  output logic [31:0] result_q,
  output logic [7:0]  status_q,
  output logic [7:0]  sticky,
  output logic        exc_req,
  output logic [7:0]  exc_cause,
  output logic [31:0] epc,
  output logic        stall
`ifdef ALU_EXC_COUNT_EN
  ,
  output logic [7:0]  exc_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic accept;
  logic exc_hit;

  // A result is taken only while the unit is not stalling upstream.
  assign accept  = alu_valid & ~stall;
  assign exc_hit = accept & ((ALU_status & EXC_MASK) != 8'h00);

  // State register; reset aborts any pending exception without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and outputs; exc_req/stall depend on the registered state only.
  always_comb begin
    state_next = state_reg;
    exc_req    = 1'b0;
    stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (exc_hit) begin
          state_next = TRAP;
        end
      end
      TRAP: begin
        exc_req = 1'b1;
        stall   = 1'b1;
        if (exc_ack) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        stall      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture of accepted result/status; reserved status bits read back as 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 32'h0;
      status_q <= 8'h00;
    end else if (accept) begin
      result_q <= ALU_result;
      status_q <= {ALU_status[7:2], 2'b00};
    end
  end

  // Sticky flags: a clear coinciding with an acceptance keeps only the new status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky <= 8'h00;
    end else if (flag_clr) begin
      sticky <= accept ? ALU_status : 8'h00;
    end else if (accept) begin
      sticky <= sticky | ALU_status;
    end
  end

  // Exception context is held until the next exception is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_cause <= 8'h00;
      epc       <= 32'h0;
    end else if (exc_hit) begin
      exc_cause <= ALU_status & EXC_MASK;
      epc       <= pc;
    end
  end

`ifdef ALU_EXC_COUNT_EN
  // Saturating exception counter; a clear in the same cycle as a new trap counts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_count <= 8'h00;
    end else if (flag_clr) begin
      exc_count <= exc_hit ? 8'd1 : 8'd0;
    end else if (exc_hit && (exc_count != 8'hFF)) begin
      exc_count <= exc_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exc_unit.sv
// tb_alu_exc_unit: scoreboard bench for alu_exc_unit. Each driven cycle pushes
// the model's expected post-edge outputs; they are popped and compared #1
// after the rising edge.
module tb_alu_exc_unit;

  localparam logic [7:0] MASK = 8'h44;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [31:0] ALU_result;
  logic [7:0]  ALU_status;
  logic [31:0] pc;
  logic        exc_ack;
  logic        flag_clr;
  logic [31:0] result_q;
  logic [7:0]  status_q;
  logic [7:0]  sticky;
  logic        exc_req;
  logic [7:0]  exc_cause;
  logic [31:0] epc;
  logic        stall;
`ifdef ALU_EXC_COUNT_EN
  logic [7:0]  exc_count;
`endif

  alu_exc_unit #(.EXC_MASK(MASK)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .ALU_result (ALU_result),
    .ALU_status (ALU_status),
    .pc         (pc),
    .exc_ack    (exc_ack),
    .flag_clr   (flag_clr),
    .result_q   (result_q),
    .status_q   (status_q),
    .sticky     (sticky),
    .exc_req    (exc_req),
    .exc_cause  (exc_cause),
    .epc        (epc),
    .stall      (stall)
`ifdef ALU_EXC_COUNT_EN
    ,
    .exc_count  (exc_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [7:0]  status;
    logic [7:0]  sticky;
    logic        exc_req;
    logic        stall;
    logic [7:0]  cause;
    logic [31:0] epc;
    logic [7:0]  count;
  } exp_t;

  exp_t sb_q[$];

  int vectors = 0;
  int errors  = 0;
  int txn     = 0;

  // Reference model state (0 idle, 1 trap, 2 drain).
  int          m_state;
  logic [31:0] m_result;
  logic [7:0]  m_status;
  logic [7:0]  m_sticky;
  logic [7:0]  m_cause;
  logic [31:0] m_epc;
  logic [7:0]  m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_result = 32'h0;
    m_status = 8'h00;
    m_sticky = 8'h00;
    m_cause  = 8'h00;
    m_epc    = 32'h0;
    m_count  = 8'h00;
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic cycle(input logic v, input logic [31:0] res, input logic [7:0] st,
                       input logic [31:0] p, input logic ack, input logic clr);
    exp_t e;
    exp_t got;
    logic acc;
    alu_valid  = v;
    ALU_result = res;
    ALU_status = st;
    pc         = p;
    exc_ack    = ack;
    flag_clr   = clr;

    acc = v && (m_state == 0);
    if (acc) begin
      m_result = res;
      m_status = {st[7:2], 2'b00};
    end
    if (clr) m_sticky = acc ? st : 8'h00;
    else if (acc) m_sticky = m_sticky | st;
    if (clr) m_count = 8'h00;
    case (m_state)
      0: if (acc && ((st & MASK) != 8'h00)) begin
           m_state = 1;
           m_cause = st & MASK;
           m_epc   = p;
           if (m_count != 8'hFF) m_count = m_count + 8'd1;
         end
      1: if (ack) m_state = 2;
      default: m_state = 0;
    endcase
    e.result  = m_result;
    e.status  = m_status;
    e.sticky  = m_sticky;
    e.exc_req = (m_state == 1);
    e.stall   = (m_state != 0);
    e.cause   = m_cause;
    e.epc     = m_epc;
    e.count   = m_count;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    txn++;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      chk("result_q",  result_q,  got.result);
      chk("status_q",  {24'h0, status_q},  {24'h0, got.status});
      chk("sticky",    {24'h0, sticky},    {24'h0, got.sticky});
      chk("exc_req",   {31'h0, exc_req},   {31'h0, got.exc_req});
      chk("stall",     {31'h0, stall},     {31'h0, got.stall});
      chk("exc_cause", {24'h0, exc_cause}, {24'h0, got.cause});
      chk("epc",       epc,       got.epc);
`ifdef ALU_EXC_COUNT_EN
      chk("exc_count", {24'h0, exc_count}, {24'h0, got.count});
`endif
    end
    $display("txn %0d v=%0b st=%h ack=%0b clr=%0b -> res=%h stq=%h sticky=%h req=%0b stall=%0b cause=%h epc=%h",
             txn, v, st, ack, clr, result_q, status_q, sticky, exc_req, stall, exc_cause, epc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_result"}, result_q, 32'h0);
    chk({tag, "_status"}, {24'h0, status_q}, 32'h0);
    chk({tag, "_sticky"}, {24'h0, sticky}, 32'h0);
    chk({tag, "_req"},    {31'h0, exc_req}, 32'h0);
    chk({tag, "_stall"},  {31'h0, stall}, 32'h0);
    chk({tag, "_cause"},  {24'h0, exc_cause}, 32'h0);
    chk({tag, "_epc"},    epc, 32'h0);
`ifdef ALU_EXC_COUNT_EN
    chk({tag, "_count"},  {24'h0, exc_count}, 32'h0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; ALU_result = 32'h0; ALU_status = 8'h00;
    pc = 32'h0; exc_ack = 1'b0; flag_clr = 1'b0;
    model_reset();

    // Asynchronous reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Plain acceptance, non-masked flags, reserved bits.
    cycle(1'b1, 32'd5, 8'h08, 32'h0000_0100, 1'b0, 1'b0);
    cycle(1'b0, 32'd7, 8'h80, 32'h0000_0104, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 8'hB8, 32'h0000_0108, 1'b0, 1'b0);
    cycle(1'b1, 32'h1234_5678, 8'h0B, 32'h0000_010C, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 8'h00, 32'h0, 1'b0, 1'b1);

    // Overflow exception, valid ignored in TRAP, ack after 3 cycles, one DRAIN.
    cycle(1'b1, 32'h0000_0042, 8'h50, 32'h0040_0010, 1'b0, 1'b0);
    cycle(1'b1, 32'd9, 8'h04, 32'h0040_0014, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 8'h00, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'd9, 8'h04, 32'h0040_0018, 1'b1, 1'b0);
    cycle(1'b1, 32'd11, 8'h44, 32'h0040_001C, 1'b0, 1'b0);
    cycle(1'b1, 32'd12, 8'h20, 32'h0040_0020, 1'b0, 1'b0);

    // Divide-by-zero exception; context held through DRAIN and after.
    cycle(1'b1, 32'd13, 8'h04, 32'h0050_0000, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 8'h00, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 8'h00, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'd14, 8'h10, 32'h0050_0004, 1'b0, 1'b0);

    // Clear alone, build sticky=88, then clear with acceptance.
    cycle(1'b0, 32'd0, 8'h00, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'd15, 8'h88, 32'h0060_0000, 1'b0, 1'b0);
    cycle(1'b1, 32'd16, 8'h10, 32'h0060_0004, 1'b0, 1'b1);

    // Reset mid-TRAP aborts the exception immediately.
    cycle(1'b1, 32'd17, 8'h44, 32'h0070_0000, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 8'h00, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1 check_reset_outputs("rst_trap");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'd18, 8'h20, 32'h0070_0004, 1'b1, 1'b0);

`ifdef ALU_EXC_COUNT_EN
    // 256 divide-by-zero exceptions saturate the counter; clear returns it to 0.
    cycle(1'b0, 32'd0, 8'h00, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, i, 8'h04, 32'h0080_0000 + i * 4, 1'b0, 1'b0);
      cycle(1'b0, 32'd0, 8'h00, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'd0, 8'h00, 32'h0, 1'b0, 1'b0);
    end
    chk("exc_count_sat", {24'h0, exc_count}, 32'd255);
    cycle(1'b0, 32'd0, 8'h00, 32'h0, 1'b0, 1'b1);
    chk("exc_count_clr", {24'h0, exc_count}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_exc_unit.md
ALU_EXC_UNIT -- requirements
Module: alu_exc_unit

Interface
REQ-001 SHALL have parameter EXC_MASK, default 8'b0100_0100, selecting the ALU_status bits that raise an exception (bit 6 overflow, bit 2 divide-by-zero).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port alu_valid  input  1  ALU_result/ALU_status valid for a committing instruction this cycle.
REQ-005 SHALL have port ALU_result  input  32  ALU result word.
REQ-006 SHALL have port ALU_status  input  8  flags: [7] zero, [6] overflow, [5] carry, [4] negative, [3] odd, [2] div-by-zero, [1:0] reserved.
REQ-007 SHALL have port pc  input  32  address of the instruction producing the ALU result.
REQ-008 SHALL have port exc_ack  input  1  handler acknowledge of the pending exception.
REQ-009 SHALL have port flag_clr  input  1  clear sticky flags.
REQ-010 SHALL have port result_q  output  32  last accepted ALU result.
REQ-011 SHALL have port status_q  output  8  last accepted status, bits [1:0] forced 0.
REQ-012 SHALL have port sticky  output  8  OR-accumulation of accepted status since last clear.
REQ-013 SHALL have port exc_req  output  1  exception pending to handler.
REQ-014 SHALL have port exc_cause  output  8  accepted status AND EXC_MASK, captured with the exception.
REQ-015 SHALL have port epc  output  32  pc of the excepting instruction.
REQ-016 SHALL have port stall  output  1  upstream shall hold; alu_valid ignored while high.

Function
REQ-017 SHALL accept a result when alu_valid=1 and stall=0; accepted data appears on result_q/status_q one cycle later.
REQ-018 SHALL ignore alu_valid while stall=1 (no capture, no sticky update).
REQ-019 SHALL update sticky as sticky | ALU_status on acceptance; flag_clr alone sets sticky to 0; flag_clr with acceptance same cycle sets sticky to the new status only.
REQ-020 SHALL implement FSM states IDLE, TRAP, DRAIN.
REQ-021 IDLE -> TRAP SHALL occur on acceptance with (ALU_status & EXC_MASK) != 0, capturing epc=pc and exc_cause=ALU_status & EXC_MASK in the same edge.
REQ-022 In TRAP, exc_req=1 and stall=1; TRAP -> DRAIN on exc_ack=1; otherwise remain in TRAP indefinitely.
REQ-023 In DRAIN, exc_req=0 and stall=1 for exactly one cycle; DRAIN -> IDLE unconditionally.
REQ-024 In IDLE, exc_req=0, stall=0; exc_ack SHALL be ignored outside TRAP.
REQ-025 exc_req and stall SHALL be decoded from the registered state only (no combinational path from inputs).
REQ-026 epc and exc_cause SHALL hold their value until the next exception capture; they are not cleared on DRAIN.
REQ-027 Non-masked flags (zero, carry, negative, odd) SHALL update status_q/sticky but never raise exc_req.

Reset
REQ-028 On rst=1, immediately: state=IDLE, result_q=0, status_q=0, sticky=0, exc_req=0, exc_cause=0, epc=0, stall=0 (and exc_count=0 when present).
REQ-029 Reset asserted in TRAP or DRAIN SHALL abort the exception with no ack required.

Configuration
REQ-030 With macro ALU_EXC_COUNT_EN defined, SHALL add output exc_count (8 bits) incrementing on each IDLE->TRAP transition, saturating at 255, cleared by flag_clr.
REQ-031 Without ALU_EXC_COUNT_EN, exc_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset, then alu_valid with ALU_result=32'd5, ALU_status=8'h08 -> next cycle result_q=5, status_q=8'h08, sticky=8'h08, exc_req=0.
REQ-033 alu_valid with ALU_status=8'h50, pc=32'h0040_0010 -> next cycle exc_req=1, stall=1, exc_cause=8'h40, epc=32'h0040_0010; exc_ack 3 cycles later -> one DRAIN cycle (stall=1, exc_req=0) then IDLE.
REQ-034 In TRAP, alu_valid with ALU_result=32'd9, ALU_status=8'h04 -> result_q, sticky, epc unchanged.
REQ-035 sticky=8'h88, flag_clr=1 with alu_valid and ALU_status=8'h10 same cycle -> sticky=8'h10.
REQ-036 rst pulsed mid-TRAP -> exc_req=0, stall=0, epc=0 immediately; with ALU_EXC_COUNT_EN, 256 div-by-zero exceptions -> exc_count=255.
